uart_cmd_parser: RTL and testbench

Command decoder downstream of the UART receiver in the IIC project. It consumes received bytes (`rx_done` / `o_rx_data`) and assembles fixed 6-byte command frames. Valid frames become single-byte I2C write or read requests toward the I2C master. A status response, plus read data for reads, goes back upstream of the UART transmitter (`data2tx` / `send_start` / `send_finsh`). It replaces the RX→TX loopback in the top level.

---
 rtl/uart_cmd_parser.sv | 215 +++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Turns 6-byte UART command frames into single-byte I2C requests and returns
// a status response (plus read data) through the UART transmitter.
module uart_cmd_parser #(
    parameter int BAUD_SET_COUNTER = 10516,
    parameter int TIMEOUT_BITS     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_done,
    input  logic [7:0] o_rx_data,
    output logic       req_valid,
    input  logic       req_ready,
    output logic       req_wr,
    output logic [6:0] req_dev,
    output logic [7:0] req_addr,
    output logic [7:0] req_wdata,
    input  logic       req_done,
    input  logic       req_err,
    input  logic [7:0] req_rdata,
    output logic [7:0] data2tx,
    output logic       send_start,
    input  logic       send_finsh,
    output logic       busy
);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * BAUD_SET_COUNTER;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [7:0] HDR      = 8'hA5;
    localparam logic [7:0] RESP_HDR = 8'h5A;
    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_NACK  = 8'h01;
    localparam logic [7:0] ST_BAD   = 8'hEE;

    typedef enum logic [2:0] {
        IDLE, COLLECT, CHECK, ISSUE, WAIT_I2C, RESP, WAIT_TX
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0][7:0]  frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [1:0]       tx_idx_q, tx_idx_d;
    logic [1:0]       tx_len_q, tx_len_d;
    logic             req_valid_q, req_valid_d;
    logic             req_wr_q, req_wr_d;
    logic [6:0]       req_dev_q, req_dev_d;
    logic [7:0]       req_addr_q, req_addr_d;
    logic [7:0]       req_wdata_q, req_wdata_d;
    logic [7:0]       data2tx_q, data2tx_d;
    logic             send_start_q, send_start_d;
    logic             busy_q, busy_d;

    logic             frame_ok;
    logic [7:0]       resp_byte;
    logic [1:0]       tx_idx_nxt;

    // frame_q holds CMD, DEV, ADDR, DATA, CHK in that order
    assign frame_ok = ((frame_q[0] ^ frame_q[1] ^ frame_q[2] ^ frame_q[3]) == frame_q[4])
                   && ((frame_q[0] == CMD_WR) || (frame_q[0] == CMD_RD))
                   && !frame_q[1][7];

    always_comb begin
        resp_byte = RESP_HDR;
        case (tx_idx_q)
            2'd0:    resp_byte = RESP_HDR;
            2'd1:    resp_byte = status_q;
            default: resp_byte = rdata_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        cnt_d        = cnt_q;
        status_d     = status_q;
        rdata_d      = rdata_q;
        tx_idx_d     = tx_idx_q;
        tx_len_d     = tx_len_q;
        req_valid_d  = req_valid_q;
        req_wr_d     = req_wr_q;
        req_dev_d    = req_dev_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        data2tx_d    = data2tx_q;
        send_start_d = 1'b0;
        tx_idx_nxt   = tx_idx_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (rx_done && (o_rx_data == HDR)) begin
                    state_d = COLLECT;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            COLLECT: begin
                if (rx_done) begin
                    frame_d[idx_q] = o_rx_data;
                    cnt_d          = '0;
                    if (idx_q == 3'd4) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CHECK: begin
                if (frame_ok) begin
                    state_d     = ISSUE;
                    req_valid_d = 1'b1;
                    req_wr_d    = (frame_q[0] == CMD_WR);
                    req_dev_d   = frame_q[1][6:0];
                    req_addr_d  = frame_q[2];
                    req_wdata_d = frame_q[3];
                end else begin
                    // Rejected frames launch their first response byte straight away
                    status_d     = ST_BAD;
                    tx_len_d     = 2'd2;
                    tx_idx_d     = 2'd0;
                    data2tx_d    = RESP_HDR;
                    send_start_d = 1'b1;
                    state_d      = WAIT_TX;
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT_I2C;
                end
            end
            WAIT_I2C: begin
                if (req_done) begin
                    status_d = req_err ? ST_NACK : ST_OK;
                    rdata_d  = req_rdata;
                    tx_len_d = (!req_wr_q && !req_err) ? 2'd3 : 2'd2;
                    tx_idx_d = 2'd0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                data2tx_d    = resp_byte;
                send_start_d = 1'b1;
                state_d      = WAIT_TX;
            end
            WAIT_TX: begin
                if (send_finsh) begin
                    tx_idx_d = tx_idx_nxt;
                    state_d  = (tx_idx_nxt < tx_len_q) ? RESP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            frame_q      <= '0;
            cnt_q        <= '0;
            status_q     <= '0;
            rdata_q      <= '0;
            tx_idx_q     <= '0;
            tx_len_q     <= '0;
            req_valid_q  <= 1'b0;
            req_wr_q     <= 1'b0;
            req_dev_q    <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            data2tx_q    <= '0;
            send_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            cnt_q        <= cnt_d;
            status_q     <= status_d;
            rdata_q      <= rdata_d;
            tx_idx_q     <= tx_idx_d;
            tx_len_q     <= tx_len_d;
            req_valid_q  <= req_valid_d;
            req_wr_q     <= req_wr_d;
            req_dev_q    <= req_dev_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            data2tx_q    <= data2tx_d;
            send_start_q <= send_start_d;
            busy_q       <= busy_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_wr     = req_wr_q;
    assign req_dev    = req_dev_q;
    assign req_addr   = req_addr_q;
    assign req_wdata  = req_wdata_q;
    assign data2tx    = data2tx_q;
    assign send_start = send_start_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame-level model, I2C and UART-TX responders,
// and a per-cycle compare process, driven by directed frames.
module tb_uart_cmd_parser;
    localparam int BAUD   = 10;
    localparam int TBITS  = 4;
    localparam int TO_CYC = BAUD * TBITS;

    typedef struct packed {
        logic       wr;
        logic [6:0] dev;
        logic [7:0] addr;
        logic [7:0] wdata;
    } req_t;

    localparam logic [47:0] WR_FRAME  = 48'hA5_01_50_10_3C_7D;
    localparam logic [47:0] RD_FRAME  = 48'hA5_02_50_20_00_72;
    localparam logic [47:0] BAD_CHK   = 48'hA5_01_50_10_3C_00;
    localparam logic [47:0] BAD_CMD   = 48'hA5_07_50_10_3C_7B;
    localparam logic [47:0] BAD_DEV   = 48'hA5_01_D0_10_3C_FD;
    localparam logic [23:0] WR_REQ    = 24'hD0_10_3C;
    localparam logic [23:0] RD_REQ    = 24'h50_20_00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] o_rx_data;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [6:0] req_dev;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_done;
    logic       req_err;
    logic [7:0] req_rdata;
    logic [7:0] data2tx;
    logic       send_start;
    logic       send_finsh;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mframe[$];
    bit         m_collect = 1'b0;
    int         m_last = 0;
    bit         engaged = 1'b0;
    req_t       exp_req[$];
    logic [7:0] exp_tx[$];
    int         exp_req_cyc = -1;
    int         exp_start_cyc = -1;
    logic [7:0] tx_log[$];
    req_t       req_log[$];

    int         ready_delay = 0;
    int         done_delay = 2;
    int         tx_delay = 6;
    bit         i2c_err = 1'b0;
    logic [7:0] i2c_rdata = 8'h00;
    bit         i2c_hang = 1'b0;

    int         i2c_phase = 0;
    int         i2c_cnt = 0;
    logic       cur_wr = 1'b0;
    bit         tx_act = 1'b0;
    int         tx_cnt = 0;

    bit         prev_acc = 1'b0;
    bit         prev_valid = 1'b0;
    bit         in_flight = 1'b0;
    logic [7:0] fly_byte = 8'h00;
    req_t       held;
    req_t       now_req;

    uart_cmd_parser #(
        .BAUD_SET_COUNTER(BAUD),
        .TIMEOUT_BITS    (TBITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_done   (rx_done),
        .o_rx_data (o_rx_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_dev   (req_dev),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .data2tx   (data2tx),
        .send_start(send_start),
        .send_finsh(send_finsh),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: hunts for the header, aborts on long gaps, drops bytes while engaged
    task automatic model_byte(input logic [7:0] b);
        req_t r;
        logic [7:0] chk;
        if (engaged) return;
        if (m_collect && (cyc - m_last > TO_CYC)) m_collect = 1'b0;
        if (!m_collect) begin
            if (b == 8'hA5) begin
                m_collect = 1'b1;
                mframe.delete();
                m_last = cyc;
            end
            return;
        end
        mframe.push_back(b);
        m_last = cyc;
        if (mframe.size() == 5) begin
            m_collect = 1'b0;
            engaged   = 1'b1;
            chk = mframe[0] ^ mframe[1] ^ mframe[2] ^ mframe[3];
            if ((chk == mframe[4]) && (mframe[0] == 8'h01 || mframe[0] == 8'h02) && !mframe[1][7]) begin
                r.wr    = (mframe[0] == 8'h01);
                r.dev   = mframe[1][6:0];
                r.addr  = mframe[2];
                r.wdata = mframe[3];
                exp_req.push_back(r);
                exp_req_cyc = cyc + 2;
            end else begin
                exp_tx.push_back(8'h5A);
                exp_tx.push_back(8'hEE);
                exp_start_cyc = cyc + 2;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done   = 1'b1;
        o_rx_data = b;
        model_byte(b);
        @(posedge clk); #1;
        rx_done   = 1'b0;
        o_rx_data = 8'h00;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) applyStimulus(f[47-8*i -: 8]);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        mframe.delete();
        exp_req.delete();
        exp_tx.delete();
        req_log.delete();
        tx_log.delete();
        m_collect     = 1'b0;
        engaged       = 1'b0;
        exp_req_cyc   = -1;
        exp_start_cyc = -1;
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string name);
        checkOutput({name, " req_valid"}, 32'(req_valid), 32'h0);
        checkOutput({name, " send_start"}, 32'(send_start), 32'h0);
        checkOutput({name, " busy"}, 32'(busy), 32'h0);
        checkOutput({name, " req_wr"}, 32'(req_wr), 32'h0);
        checkOutput({name, " req_dev"}, 32'(req_dev), 32'h0);
        checkOutput({name, " req_addr"}, 32'(req_addr), 32'h0);
        checkOutput({name, " req_wdata"}, 32'(req_wdata), 32'h0);
        checkOutput({name, " data2tx"}, 32'(data2tx), 32'h0);
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while (engaged && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checkOutput({name, " completes"}, 32'(engaged), 32'h0);
        if (engaged) do_reset();
        repeat (4) @(posedge clk);
        #1;
        checkOutput({name, " busy after"}, 32'(busy), 32'h0);
        checkOutput({name, " leftover tx"}, 32'(exp_tx.size()), 32'h0);
        checkOutput({name, " leftover req"}, 32'(exp_req.size()), 32'h0);
    endtask

    task automatic expect_log(input string name, input int n, input logic [23:0] bytes);
        checkOutput({name, " tx count"}, 32'(tx_log.size()), 32'(n));
        for (int i = 0; i < n && i < tx_log.size(); i++)
            checkOutput({name, " tx byte"}, 32'(tx_log[i]), 32'(bytes[23-8*i -: 8]));
        tx_log.delete();
    endtask

    task automatic expect_req(input string name, input int n, input logic [23:0] r);
        checkOutput({name, " req count"}, 32'(req_log.size()), 32'(n));
        if (n > 0 && req_log.size() > 0)
            checkOutput({name, " req fields"}, 32'(req_log[0]), 32'(r));
        req_log.delete();
    endtask

    // I2C master stand-in: delayed ready, then a done pulse carrying err/rdata
    initial begin
        req_ready = 1'b0;
        req_done  = 1'b0;
        req_err   = 1'b0;
        req_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            req_ready = 1'b0;
            req_done  = 1'b0;
            req_err   = 1'b0;
            req_rdata = 8'h00;
            if (!rst_n) begin
                i2c_phase = 0;
                continue;
            end
            if (i2c_phase == 0 && req_valid) begin
                i2c_cnt   = ready_delay;
                i2c_phase = 1;
            end
            if (i2c_phase == 1) begin
                if (i2c_cnt == 0) begin
                    req_ready = 1'b1;
                    cur_wr    = req_wr;
                    i2c_phase = 2;
                end else begin
                    i2c_cnt--;
                end
            end else if (i2c_phase == 2) begin
                i2c_cnt   = done_delay;
                i2c_phase = 3;
            end else if (i2c_phase == 3 && !i2c_hang) begin
                if (i2c_cnt == 0) begin
                    req_done  = 1'b1;
                    req_err   = i2c_err;
                    req_rdata = i2c_rdata;
                    exp_tx.push_back(8'h5A);
                    exp_tx.push_back(i2c_err ? 8'h01 : 8'h00);
                    if (!cur_wr && !i2c_err) exp_tx.push_back(i2c_rdata);
                    exp_start_cyc = cyc + 2;
                    i2c_phase = 0;
                end else begin
                    i2c_cnt--;
                end
            end
        end
    end

    // UART transmitter stand-in: finishes each byte tx_delay cycles after its start
    initial begin
        send_finsh = 1'b0;
        forever begin
            @(posedge clk); #1;
            send_finsh = 1'b0;
            if (!rst_n) begin
                tx_act = 1'b0;
                continue;
            end
            if (!tx_act && send_start) begin
                tx_act = 1'b1;
                tx_cnt = tx_delay;
            end else if (tx_act) begin
                if (tx_cnt == 0) begin
                    send_finsh = 1'b1;
                    tx_act     = 1'b0;
                    if (exp_tx.size() > 0) exp_start_cyc = cyc + 2;
                    else engaged = 1'b0;
                end else begin
                    tx_cnt--;
                end
            end
        end
    end

    // Per-cycle compare of the DUT outputs against the model's expectations
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_acc   = 1'b0;
                prev_valid = 1'b0;
                in_flight  = 1'b0;
                continue;
            end
            now_req = {req_wr, req_dev, req_addr, req_wdata};
            if (prev_acc) checkOutput("req_valid falls after accept", 32'(req_valid), 32'h0);
            if (req_valid && prev_valid && !prev_acc)
                checkOutput("req fields stable", 32'(now_req), 32'(held));
            if (req_valid && !prev_valid) begin
                checkOutput("req_valid latency", 32'(cyc), 32'(exp_req_cyc));
                exp_req_cyc = -1;
            end
            if (exp_req_cyc == cyc && !req_valid)
                checkOutput("req_valid rise", 32'(req_valid), 32'h1);
            if (req_valid || send_start || in_flight)
                checkOutput("busy while active", 32'(busy), 32'h1);
            prev_acc = req_valid && req_ready;
            if (prev_acc) begin
                checkOutput("request expected", 32'(exp_req.size() != 0), 32'h1);
                if (exp_req.size() != 0)
                    checkOutput("req fields", 32'(now_req), 32'(exp_req.pop_front()));
                req_log.push_back(now_req);
            end
            held       = now_req;
            prev_valid = req_valid;

            if (send_start) begin
                checkOutput("single byte in flight", 32'(in_flight), 32'h0);
                checkOutput("send_start timing", 32'(cyc), 32'(exp_start_cyc));
                exp_start_cyc = -1;
                checkOutput("response byte expected", 32'(exp_tx.size() != 0), 32'h1);
                if (exp_tx.size() != 0)
                    checkOutput("data2tx", 32'(data2tx), 32'(exp_tx.pop_front()));
                tx_log.push_back(data2tx);
                in_flight = 1'b1;
                fly_byte  = data2tx;
            end else if (in_flight) begin
                checkOutput("data2tx stable", 32'(data2tx), 32'(fly_byte));
                if (send_finsh) in_flight = 1'b0;
            end
            if (exp_start_cyc == cyc && !send_start)
                checkOutput("send_start missing", 32'(send_start), 32'h1);
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        rx_done   = 1'b0;
        o_rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        check_reset_vals("initial reset");

        send_frame(WR_FRAME);
        wait_quiet("write");
        expect_log("write", 2, 24'h5A_00_00);
        expect_req("write", 1, WR_REQ);

        ready_delay = 5;
        i2c_rdata   = 8'hC3;
        send_frame(RD_FRAME);
        wait_quiet("read");
        expect_log("read", 3, 24'h5A_00_C3);
        expect_req("read", 1, RD_REQ);
        ready_delay = 0;

        send_frame(BAD_CHK);
        wait_quiet("bad chk");
        expect_log("bad chk", 2, 24'h5A_EE_00);
        expect_req("bad chk", 0, 24'h0);

        send_frame(BAD_CMD);
        wait_quiet("bad cmd");
        expect_log("bad cmd", 2, 24'h5A_EE_00);
        expect_req("bad cmd", 0, 24'h0);

        send_frame(BAD_DEV);
        wait_quiet("bad dev");
        expect_log("bad dev", 2, 24'h5A_EE_00);
        expect_req("bad dev", 0, 24'h0);

        i2c_err = 1'b1;
        send_frame(RD_FRAME);
        wait_quiet("nack");
        expect_log("nack", 2, 24'h5A_01_00);
        expect_req("nack", 1, RD_REQ);
        i2c_err = 1'b0;

        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h5A);
        send_frame(WR_FRAME);
        wait_quiet("garbage");
        expect_log("garbage", 2, 24'h5A_00_00);
        expect_req("garbage", 1, WR_REQ);

        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h50);
        #1;
        checkOutput("busy mid-frame", 32'(busy), 32'h1);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("busy after timeout", 32'(busy), 32'h0);
        expect_log("timeout silence", 0, 24'h0);
        send_frame(WR_FRAME);
        wait_quiet("after timeout");
        expect_log("after timeout", 2, 24'h5A_00_00);
        expect_req("after timeout", 1, WR_REQ);

        i2c_hang = 1'b1;
        send_frame(RD_FRAME);
        n = 0;
        while (req_log.size() == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wait_i2c accepted", 32'(req_log.size()), 32'h1);
        checkOutput("busy in wait_i2c", 32'(busy), 32'h1);
        do_reset();
        check_reset_vals("reset in wait_i2c");
        i2c_hang = 1'b0;
        repeat (20) @(posedge clk);
        expect_log("reset abandons", 0, 24'h0);
        send_frame(WR_FRAME);
        wait_quiet("after reset");
        expect_log("after reset", 2, 24'h5A_00_00);
        expect_req("after reset", 1, WR_REQ);

        ready_delay = 30;
        send_frame(RD_FRAME);
        n = 0;
        while (!req_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("issue pending", 32'(req_valid), 32'h1);
        do_reset();
        checkOutput("req_valid dropped by reset", 32'(req_valid), 32'h0);
        ready_delay = 0;
        repeat (40) @(posedge clk);
        expect_req("reset in issue", 0, 24'h0);
        expect_log("reset in issue", 0, 24'h0);

        tx_delay = 20;
        send_frame(WR_FRAME);
        n = 0;
        while (tx_log.size() == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        send_frame(RD_FRAME);
        wait_quiet("drop in wait_tx");
        expect_log("drop in wait_tx", 2, 24'h5A_00_00);
        expect_req("drop in wait_tx", 1, WR_REQ);
        tx_delay = 6;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
